// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter: FSM state encoding,
// access-owner tag, debug access mask and default widths.
`timescale 1ns/1ps
package dmem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF       = 14;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_CNT_W     = 4;

  // Debug port always performs full-word accesses.
  localparam logic [3:0] DBG_SIGN_MASK = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CPU_ISSUE = 3'd1,
    ST_DBG_ISSUE = 3'd2,
    ST_WAIT_MEM  = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_rr_starve_ctr.sv
// Grant decision for the memory port: CPU wins ties until it has been granted
// STARVE_LIMIT times in a row with a debug request waiting, then debug gets a turn.
`timescale 1ns/1ps
module dmem_rr_starve_ctr
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en_i,
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  output logic grant_cpu_o,
  output logic grant_dbg_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    grant_dbg_o = 1'b0;
    grant_cpu_o = 1'b0;
    cnt_d       = cnt_q;
    if (arb_en_i) begin
      grant_dbg_o = dbg_req_i && (!cpu_req_i || (cnt_q == LIMIT));
      grant_cpu_o = cpu_req_i && !grant_dbg_o;
      if (grant_dbg_o) begin
        cnt_d = '0;
      end else if (grant_cpu_o) begin
        if (!dbg_req_i) begin
          cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
          cnt_d = cnt_q + STARVE_CNT_W'(1);
        end
      end
    end
  end

  // NOTE: registers are updated with non-blocking assignments so all state sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the cached data memory between the CPU load/store port and a debug/DMA port.
// One access at a time: registered issue, wait out the miss stall, one-cycle response.
`timescale 1ns/1ps
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_memwrite,
  input  logic              cpu_memread,
  input  logic [3:0]        cpu_sign_mask,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_stall
);

  arb_state_t        state_q;
  owner_t            owner_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [3:0]        mem_mask_q;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       dbg_rdata_q;
  logic              dbg_ack_q;

  logic cpu_req;
  logic grant_cpu;
  logic grant_dbg;

  assign cpu_req = cpu_memread | cpu_memwrite;

  dmem_rr_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .arb_en_i   (state_q == ST_IDLE),
    .cpu_req_i  (cpu_req),
    .dbg_req_i  (dbg_req),
    .grant_cpu_o(grant_cpu),
    .grant_dbg_o(grant_dbg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_mask_q  <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      dbg_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_dbg) begin
            state_q     <= ST_DBG_ISSUE;
            owner_q     <= OWN_DBG;
            mem_addr_q  <= dbg_addr;
            mem_wdata_q <= dbg_wdata;
            mem_we_q    <= dbg_we;
            mem_re_q    <= !dbg_we;
            mem_mask_q  <= DBG_SIGN_MASK;
          end else if (grant_cpu) begin
            state_q     <= ST_CPU_ISSUE;
            owner_q     <= OWN_CPU;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
            mem_we_q    <= cpu_memwrite;
            mem_re_q    <= cpu_memread;
            mem_mask_q  <= cpu_sign_mask;
          end
        end
        ST_CPU_ISSUE, ST_DBG_ISSUE: begin
          state_q <= ST_WAIT_MEM;
        end
        ST_WAIT_MEM: begin
          if (!mem_stall) begin
            state_q   <= ST_RESP;
            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
            dbg_ack_q <= (owner_q == OWN_DBG);
            // Only reads update the owner's result register; stores leave it alone.
            if (mem_re_q) begin
              if (owner_q == OWN_DBG) dbg_rdata_q <= mem_read_data;
              else                    cpu_rdata_q <= mem_read_data;
            end
          end
        end
        ST_RESP: begin
          state_q   <= ST_IDLE;
          dbg_ack_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_we_q  <= 1'b0;
          mem_re_q  <= 1'b0;
          dbg_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the CPU freezes in the same cycle it raises a request;
  // it is forced low while reset is asserted.
  assign cpu_stall = rst_n & cpu_req & ~((state_q == ST_RESP) & (owner_q == OWN_CPU));

  assign cpu_rdata      = cpu_rdata_q;
  assign dbg_rdata      = dbg_rdata_q;
  assign dbg_ack        = dbg_ack_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_memwrite   = mem_we_q;
  assign mem_memread    = mem_re_q;
  assign mem_sign_mask  = mem_mask_q;

endmodule
